// File: rtl/bus_xfer_ctrl_pkg.sv
// Register-op encoding shared with the bus registers, plus the transfer FSM states.
package control;

   typedef enum logic [1:0] {
      NOP    = 2'b00,
      ENABLE = 2'b01,
      LOAD   = 2'b10,
      RSVD   = 2'b11
   } reg_op_e;

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      COMMIT,
      REJECT
   } xfer_state_e;

endpackage

// File: rtl/bus_xfer_ctrl.sv
// Register-to-register bus mover: ENABLE src, then ENABLE src + LOAD dst; done/err pulse the cycle after.
// Three cycles per move, two per reject; req_ready is high only in IDLE, so requests are held off while busy.
module bus_xfer_ctrl
   import control::*;
#(
   parameter int NUM_REGS = 4,
   parameter int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [IDX_W-1:0] req_src,
   input  logic [IDX_W-1:0] req_dst,
   output reg_op_e          reg_ops [NUM_REGS],
   input  logic [7:0]       bus_data,
   output logic [7:0]       xfer_data,
   output logic             done,
   output logic             err,
   output logic             busy
);

   xfer_state_e      state;
   xfer_state_e      state_nxt;
   logic [IDX_W-1:0] src_q;
   logic [IDX_W-1:0] dst_q;
   logic             accept;
   logic             bad_req;

   assign req_ready = (state == IDLE);
   assign busy      = (state != IDLE);
   assign accept    = req_valid && req_ready;
   assign bad_req   = (int'(req_src) >= NUM_REGS) || (int'(req_dst) >= NUM_REGS) ||
                      (req_src == req_dst);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = bad_req ? REJECT : DRIVE;
         DRIVE:   state_nxt = COMMIT;
         COMMIT:  state_nxt = IDLE;
         REJECT:  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         xfer_data <= 8'h00;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         state <= state_nxt;
         done  <= (state == COMMIT);
         err   <= (state == REJECT);
         if (accept) begin
            src_q <= req_src;
            dst_q <= req_dst;
         end
         // Source has been driving for a full cycle by now, so the bus is settled.
         if (state == COMMIT) xfer_data <= bus_data;
      end
   end

   // Decode uses only the latched indices, so live request inputs cannot disturb a move.
   for (genvar i = 0; i < NUM_REGS; i++) begin : g_op
      localparam logic [IDX_W-1:0] IDX = IDX_W'(i);
      assign reg_ops[i] = (state == COMMIT && dst_q == IDX)                     ? LOAD   :
                          ((state == DRIVE || state == COMMIT) && src_q == IDX) ? ENABLE :
                                                                                  NOP;
   end

endmodule
